bisr_stw_scheduler: RTL

Top-level sequencer for the BISR systolic array. On a run request it drives a fixed sequence of Stop-the-World (STW) test patterns into the array and accumulates a sticky per-PE fault map from STW_result_mat. It then either releases the array for a matrix multiply or declares the array unrepairable. It sits between the system controller and bisr_systolic_top, and owns STW_*, start_fsm and start_matmul.

---
 rtl/bisr_ctl_pkg.sv | 48 ++++
 rtl/stw_pattern_rom.sv | 19 +
 rtl/bisr_stw_scheduler.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/bisr_ctl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bisr_ctl_pkg
//  Purpose  : Shared types and the Stop-the-World pattern table used by the
//             BISR scheduler and its pattern ROM.
//  Contents : state_t        - scheduler FSM states
//             stw_pattern_t  - one STW operand set plus its expected result
//             STW_PATTERN_TABLE - eight fixed test patterns
//  Revision : 1.0 - initial release
// ============================================================================
package bisr_ctl_pkg;

    localparam int STW_W           = 8;
    localparam int NUM_ROM_ENTRIES = 8;
    localparam int IDX_W           = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        START  = 3'd2,
        WAIT   = 3'd3,
        EVAL   = 3'd4,
        MATMUL = 3'd5,
        MWAIT  = 3'd6,
        FINISH = 3'd7
    } state_t;

    typedef struct packed {
        logic [STW_W-1:0] op1;
        logic [STW_W-1:0] op2;
        logic [STW_W-1:0] add;
        logic [STW_W-1:0] expected;
    } stw_pattern_t;

    // expected = (op1*op2 + add) mod 256; the carry is deliberately dropped.
    localparam stw_pattern_t STW_PATTERN_TABLE [NUM_ROM_ENTRIES] = '{
        '{8'd4,   8'd3,   8'd1,   8'd13},
        '{8'd0,   8'd0,   8'd0,   8'd0},
        '{8'd255, 8'd1,   8'd0,   8'd255},
        '{8'd170, 8'd1,   8'd85,  8'd255},
        '{8'd1,   8'd255, 8'd1,   8'd0},
        '{8'd15,  8'd17,  8'd0,   8'd255},
        '{8'd2,   8'd2,   8'd255, 8'd3},
        '{8'd16,  8'd16,  8'd0,   8'd0}
    };

endpackage
`default_nettype wire

// File: rtl/stw_pattern_rom.sv
`default_nettype none
// ============================================================================
//  Module   : stw_pattern_rom
//  Purpose  : Combinational lookup of one STW test pattern.
//  Ports    : idx     in  pattern index (0..7)
//             pattern out operands and expected result for idx
//  Revision : 1.0 - initial release
// ============================================================================
module stw_pattern_rom
    import bisr_ctl_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output stw_pattern_t     pattern
);

    assign pattern = STW_PATTERN_TABLE[idx];

endmodule
`default_nettype wire

// File: rtl/bisr_stw_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : bisr_stw_scheduler
//  Purpose  : Runs a fixed series of Stop-the-World patterns through the
//             systolic array, accumulates a sticky per-PE fault map, then
//             either launches the matrix multiply or flags the array as
//             unrepairable.
//  Ports    : clk, rst (sync, active high), run_req
//             STW_* operand/control outputs, STW_complete/STW_result_mat in
//             start_fsm/start_matmul out, matmul_in_progress/_output_done in
//             fault_map, fault_count, busy, done, unrepairable, timeout_err
//  Notes    : The pattern table is 8 bits wide; with WORD_SIZE other than 8
//             the operands are resized and the expected value is only exact
//             for the default width.
//  Revision : 1.0 - initial release
// ============================================================================
module bisr_stw_scheduler
    import bisr_ctl_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int WORD_SIZE      = 8,
    parameter int NUM_PATTERNS   = 4,
    parameter int MAX_FAULTS     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             run_req,
    output logic                             STW_test_load_en,
    output logic [WORD_SIZE-1:0]             STW_mult_op1,
    output logic [WORD_SIZE-1:0]             STW_mult_op2,
    output logic [WORD_SIZE-1:0]             STW_add_op,
    output logic [WORD_SIZE-1:0]             STW_expected,
    output logic                             STW_start,
    input  logic                             STW_complete,
    input  logic [ROWS*COLS-1:0]             STW_result_mat,
    output logic                             start_fsm,
    output logic                             start_matmul,
    input  logic                             matmul_in_progress,
    input  logic                             matmul_output_done,
    output logic [ROWS*COLS-1:0]             fault_map,
    output logic [$clog2(ROWS*COLS+1)-1:0]   fault_count,
    output logic                             busy,
    output logic                             done,
    output logic                             unrepairable,
    output logic                             timeout_err
);

    localparam int NPE   = ROWS * COLS;
    localparam int CNT_W = $clog2(NPE + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PATTERNS - 1);
    localparam logic [CNT_W-1:0] MAX_F    = CNT_W'(MAX_FAULTS);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    state_t               r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [TMR_W-1:0]     r_timer;
    logic                 r_load_en;
    logic                 r_stw_start;
    logic [WORD_SIZE-1:0] r_op1;
    logic [WORD_SIZE-1:0] r_op2;
    logic [WORD_SIZE-1:0] r_add;
    logic [WORD_SIZE-1:0] r_exp;
    logic                 r_start_fsm;
    logic                 r_start_matmul;
    logic [NPE-1:0]       r_fault_map;
    logic [CNT_W-1:0]     r_fault_count;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_unrep;
    logic                 r_timeout;

    logic [IDX_W-1:0]     w_rom_idx;
    stw_pattern_t         w_pattern;
    logic [CNT_W-1:0]     w_popcount;

    // The ROM is only consulted on the edges that enter LOAD: from IDLE the
    // first pattern is needed, from WAIT the one after the current index.
    assign w_rom_idx = (r_state == WAIT) ? IDX_W'(r_idx + IDX_W'(1)) : '0;

    stw_pattern_rom u_rom (
        .idx     (w_rom_idx),
        .pattern (w_pattern)
    );

    always_comb begin
        w_popcount = '0;
        for (int i = 0; i < NPE; i++) begin
            w_popcount = w_popcount + CNT_W'(r_fault_map[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_idx          <= '0;
            r_timer        <= '0;
            r_load_en      <= 1'b0;
            r_stw_start    <= 1'b0;
            r_op1          <= '0;
            r_op2          <= '0;
            r_add          <= '0;
            r_exp          <= '0;
            r_start_fsm    <= 1'b0;
            r_start_matmul <= 1'b0;
            r_fault_map    <= '0;
            r_fault_count  <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_unrep        <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            // Single-cycle pulses fall by default.
            r_load_en   <= 1'b0;
            r_stw_start <= 1'b0;
            r_done      <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (run_req) begin
                        r_state       <= LOAD;
                        r_idx         <= '0;
                        r_fault_map   <= '0;
                        r_fault_count <= '0;
                        r_unrep       <= 1'b0;
                        r_timeout     <= 1'b0;
                        r_busy        <= 1'b1;
                        r_load_en     <= 1'b1;
                        r_op1         <= WORD_SIZE'(w_pattern.op1);
                        r_op2         <= WORD_SIZE'(w_pattern.op2);
                        r_add         <= WORD_SIZE'(w_pattern.add);
                        r_exp         <= WORD_SIZE'(w_pattern.expected);
                    end
                end

                LOAD: begin
                    r_state     <= START;
                    r_stw_start <= 1'b1;
                    r_timer     <= '0;
                end

                START: begin
                    r_state <= WAIT;
                end

                WAIT: begin
                    // A completion in the expiry cycle is still accepted.
                    if (STW_complete) begin
                        r_fault_map <= r_fault_map | ~STW_result_mat;
                        if (r_idx < LAST_IDX) begin
                            r_state   <= LOAD;
                            r_idx     <= IDX_W'(r_idx + IDX_W'(1));
                            r_load_en <= 1'b1;
                            r_op1     <= WORD_SIZE'(w_pattern.op1);
                            r_op2     <= WORD_SIZE'(w_pattern.op2);
                            r_add     <= WORD_SIZE'(w_pattern.add);
                            r_exp     <= WORD_SIZE'(w_pattern.expected);
                        end else begin
                            r_state <= EVAL;
                        end
                    end else if (r_timer == TMO_LAST) begin
                        r_timeout <= 1'b1;
                        r_state   <= FINISH;
                        r_done    <= 1'b1;
                    end else begin
                        r_timer <= TMR_W'(r_timer + TMR_W'(1));
                    end
                end

                EVAL: begin
                    r_fault_count <= w_popcount;
                    if (w_popcount > MAX_F) begin
                        r_unrep <= 1'b1;
                        r_state <= FINISH;
                        r_done  <= 1'b1;
                    end else begin
                        r_state        <= MATMUL;
                        r_start_fsm    <= 1'b1;
                        r_start_matmul <= 1'b1;
                    end
                end

                MATMUL: begin
                    if (matmul_in_progress) begin
                        r_state        <= MWAIT;
                        r_start_fsm    <= 1'b0;
                        r_start_matmul <= 1'b0;
                        r_timer        <= '0;
                    end
                end

                MWAIT: begin
                    if (matmul_output_done) begin
                        r_state <= FINISH;
                        r_done  <= 1'b1;
                    end else if (r_timer == TMO_LAST) begin
                        r_timeout <= 1'b1;
                        r_state   <= FINISH;
                        r_done    <= 1'b1;
                    end else begin
                        r_timer <= TMR_W'(r_timer + TMR_W'(1));
                    end
                end

                FINISH: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign STW_test_load_en = r_load_en;
    assign STW_mult_op1     = r_op1;
    assign STW_mult_op2     = r_op2;
    assign STW_add_op       = r_add;
    assign STW_expected     = r_exp;
    assign STW_start        = r_stw_start;
    assign start_fsm        = r_start_fsm;
    assign start_matmul     = r_start_matmul;
    assign fault_map        = r_fault_map;
    assign fault_count      = r_fault_count;
    assign busy             = r_busy;
    assign done             = r_done;
    assign unrepairable     = r_unrep;
    assign timeout_err      = r_timeout;

endmodule
`default_nettype wire
